// File: rtl/sublime_nco_pkg.sv
// Shared constants for the sublime NCO voice-path block.
package sublime_nco_pkg;

  // Default phase accumulator / address width.
  localparam int NCO_WIDTH = 32;

endpackage : sublime_nco_pkg

// File: rtl/sublime_nco.sv
// Numerically controlled oscillator: a phase accumulator plus a registered
// phase-offset adder that drives the wavetable address.
module sublime_nco
  import sublime_nco_pkg::*;
#(
  parameter int WIDTH = NCO_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             sync,
  input  logic [WIDTH-1:0] freq,
  input  logic [WIDTH-1:0] offset,
  output logic [WIDTH-1:0] wave_addr
);

  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] acc_d;
  logic [WIDTH-1:0] wave_q;
  logic [WIDTH-1:0] wave_d;

  // Next phase: sync restarts the phase and wins over enable; wrap is silent.
  always_comb begin
    acc_d = acc_q;
    if (sync) begin
      acc_d = '0;
    end else if (enable) begin
      acc_d = acc_q + freq;
    end
  end

  // Address uses the pre-update phase, so it trails the accumulator by one edge
  // and still follows offset changes while the phase is held.
  always_comb begin
    wave_d = acc_q + offset;
  end

  // Accumulator and output registers; reset clears both on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q  <= '0;
      wave_q <= '0;
    end else begin
      acc_q  <= acc_d;
      wave_q <= wave_d;
    end
  end

  assign wave_addr = wave_q;

endmodule : sublime_nco

// File: tb/tb_sublime_nco.sv
// Directed bench for sublime_nco: reset, run, wrap, hold, sync, half-scale
// toggle and a mid-run reset followed by randomised tuning against a model.
module tb_sublime_nco;

  logic        clk;
  logic        rst;
  logic        enable;
  logic        sync;
  logic [31:0] freq;
  logic [31:0] offset;
  logic [31:0] wave_addr;

  int n_pass;
  int n_total;

  logic [31:0] m_acc;
  logic [31:0] exp_w;

  sublime_nco #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .sync      (sync),
    .freq      (freq),
    .offset    (offset),
    .wave_addr (wave_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One rising edge, then settle before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_total++;
    assert (obs === expv) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, expv);
    end
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    rst     = 1'b1;
    enable  = 1'b0;
    sync    = 1'b0;
    freq    = 32'h0800_0000;
    offset  = 32'h1000_0000;

    // Reset held for 10 cycles: address stays zero.
    for (int i = 0; i < 10; i++) begin
      tick();
      check("reset", wave_addr, 32'h0000_0000);
    end

    // Basic run and wrap: wave_n = acc_(n-1) + offset, acc steps by 1/32 turn.
    rst    = 1'b0;
    enable = 1'b1;
    for (int n = 1; n <= 34; n++) begin
      tick();
      exp_w = 32'h1000_0000 + 32'(n - 1) * 32'h0800_0000;
      check("run_wrap", wave_addr, exp_w);
    end
    // acc is now 34 * 0x08000000 mod 2^32 = 0x10000000.

    // Hold for 5 cycles: address settles to acc + offset and stays there.
    enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("hold", wave_addr, 32'h2000_0000);
    end
    // Offset change while held shows up on the next edge.
    offset = 32'h0000_0000;
    tick();
    check("hold_offset0", wave_addr, 32'h1000_0000);

    // Sync with enable=1.
    offset = 32'h0300_0000;
    sync   = 1'b1;
    enable = 1'b1;
    tick();
    check("sync_en_edge", wave_addr, 32'h1300_0000);
    sync = 1'b0;
    tick();
    check("sync_en_next", wave_addr, 32'h0300_0000);
    tick();
    check("sync_en_next2", wave_addr, 32'h0B00_0000);

    // Sync with enable=0 behaves the same. acc is 0x10000000 here.
    sync   = 1'b1;
    enable = 1'b0;
    tick();
    check("sync_dis_edge", wave_addr, 32'h1300_0000);
    sync   = 1'b0;
    enable = 1'b1;
    tick();
    check("sync_dis_next", wave_addr, 32'h0300_0000);
    tick();
    check("sync_dis_next2", wave_addr, 32'h0B00_0000);

    // Half-scale tuning word toggles between 0 and half-scale.
    sync = 1'b1;
    freq = 32'h8000_0000;
    tick();
    sync = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      exp_w = (i % 2 == 0) ? 32'h0300_0000 : 32'h8300_0000;
      check("half_scale", wave_addr, exp_w);
    end

    // freq=0 holds a constant phase. acc is 0 after the 4 toggle steps.
    freq = 32'h0000_0000;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("freq_zero", wave_addr, 32'h0300_0000);
    end

    // Mid-run reset pulse: both registers clear on that edge.
    freq = 32'h0123_4567;
    rst  = 1'b1;
    tick();
    check("reset_mid", wave_addr, 32'h0000_0000);
    rst   = 1'b0;
    m_acc = 32'h0000_0000;

    // Randomised tuning after release, checked against a mod-2^32 model.
    for (int i = 0; i < 20; i++) begin
      freq   = $urandom;
      offset = $urandom;
      exp_w  = m_acc + offset;
      m_acc  = m_acc + freq;
      tick();
      check("random_run", wave_addr, exp_w);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_sublime_nco
